// File: rtl/ble_uart_command_enc_tx.sv
// BLE UART command frame encoder: latches a command on start, then streams
// opcode, address, length, payload and an XOR checksum over valid/ready.
module ble_uart_command_enc_tx (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] cmd_select,
  input  logic        encrypt_enable,
  input  logic [47:0] target_addr,
  input  logic [15:0] yaw_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done,
  output logic        error
);

  localparam logic [7:0]  OPC_ENC     = 8'h01;
  localparam logic [7:0]  OPC_YAW_REQ = 8'h03;
  localparam logic [7:0]  OPC_YAW_RSP = 8'h04;
  localparam logic [47:0] BCAST_ADDR  = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [9:0][7:0] frame_q, frame_d;   // header + payload, byte i = frame[i]
  logic [3:0]      last_idx_q, last_idx_d;
  logic [3:0]      idx_q;
  logic [7:0]      csum_q;
  logic [7:0]      cur_byte;
  logic            legal;
  logic            accept;
  logic            handshake;

  // Frame image for the selected command; checksum is accumulated on the fly.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    legal      = 1'b1;
    frame_d    = '0;
    last_idx_d = 4'd7;
    case (cmd_select)
      16'd1: begin
        frame_d    = {8'h00, 7'b0, encrypt_enable, 8'd1, BCAST_ADDR, OPC_ENC};
        last_idx_d = 4'd8;
      end
      16'd2: begin
        frame_d    = {16'h0000, 8'd0, target_addr, OPC_YAW_REQ};
        last_idx_d = 4'd7;
      end
      16'd3: begin
        frame_d    = {yaw_data, 8'd2, target_addr, OPC_YAW_RSP};
        last_idx_d = 4'd9;
      end
      default: legal = 1'b0;
    endcase
  end

  assign accept    = (state_q == IDLE) && start && legal;
  assign cur_byte  = frame_q[idx_q];
  assign tx_valid  = (state_q != IDLE);
  assign done      = (state_q == IDLE);
  assign handshake = tx_valid && tx_ready;

  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      SEND:    tx_data = cur_byte;
      CSUM:    tx_data = csum_q;
      default: tx_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = SEND;
      SEND: if (handshake && (idx_q == last_idx_q)) state_d = CSUM;
      CSUM: if (handshake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      error   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            error <= !legal;
            if (legal) begin
              idx_q  <= '0;
              csum_q <= '0;
            end
          end
        end
        SEND: begin
          if (handshake) begin
            idx_q  <= idx_q + 4'd1;
            csum_q <= csum_q ^ cur_byte;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the frame image carries no reset; it is only observed outside IDLE,
  // and every entry into SEND reloads it first.
  always_ff @(posedge clk) begin
    if (accept) begin
      frame_q    <= frame_d;
      last_idx_q <= last_idx_d;
    end
  end

endmodule

// File: tb/tb_ble_uart_command_enc_tx.sv
// Self-checking bench for ble_uart_command_enc_tx: a queue-based frame model
// built from the byte layout rules, directed test-plan cases and random frames.
module tb_ble_uart_command_enc_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cmd_select = '0;
  logic        encrypt_enable = 1'b0;
  logic [47:0] target_addr = '0;
  logic [15:0] yaw_data = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        done;
  logic        error;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] exp_q[$];

  ble_uart_command_enc_tx dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .cmd_select     (cmd_select),
    .encrypt_enable (encrypt_enable),
    .target_addr    (target_addr),
    .yaw_data       (yaw_data),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  // Reference frame: opcode, address LS byte first, length, payload, XOR.
  task automatic build_expected(input int cmd, input logic ee,
                                input logic [47:0] addr, input logic [15:0] yaw);
    logic [47:0] a;
    logic [7:0]  x;
    exp_q.delete();
    a = (cmd == 1) ? 48'hFFFF_FFFF_FFFF : addr;
    exp_q.push_back(cmd == 1 ? 8'h01 : (cmd == 2 ? 8'h03 : 8'h04));
    for (int i = 0; i < 6; i++) exp_q.push_back(8'((a >> (8 * i)) & 48'hFF));
    if (cmd == 1) begin
      exp_q.push_back(8'd1);
      exp_q.push_back(ee ? 8'd1 : 8'd0);
    end else if (cmd == 2) begin
      exp_q.push_back(8'd0);
    end else begin
      exp_q.push_back(8'd2);
      exp_q.push_back(yaw % 256);
      exp_q.push_back(yaw / 256);
    end
    x = 8'h00;
    foreach (exp_q[i]) x = x ^ exp_q[i];
    exp_q.push_back(x);
  endtask

  // Starts a frame at the current negedge and collects it. ready_mode:
  // 0 = always ready, 1 = toggle 1/0, 2 = random. inject_at >= 0 pulses a
  // foreign start in that frame cycle. Returns at the negedge where done is back.
  task automatic run_frame(input string name, input int cmd, input logic ee,
                           input logic [47:0] addr, input logic [15:0] yaw,
                           input int ready_mode, input int inject_at);
    logic [7:0] got[$];
    logic [7:0] prev_data;
    logic       prev_stall;
    logic       rdy;
    int         cyc;
    build_expected(cmd, ee, addr, yaw);
    cmd_select = 16'(cmd); encrypt_enable = ee; target_addr = addr; yaw_data = yaw;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmd_select = 16'($urandom_range(1, 3)); encrypt_enable = ~ee;
    target_addr = {$urandom, $urandom}; yaw_data = 16'($urandom);
    prev_stall = 1'b0; prev_data = '0; cyc = 0;
    while (cyc < 200) begin
      start = (cyc == inject_at);
      rdy = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? (cyc % 2 == 0) : 1'($urandom % 2);
      tx_ready = rdy;
      if (!tx_valid) break;
      if (prev_stall) begin
        total_cnt++;
        if (tx_data !== prev_data)
          $display("FAIL %s stall_stable: tx_data=%h required=%h", name, tx_data, prev_data);
        else pass_cnt++;
      end
      if (rdy) got.push_back(tx_data);
      prev_stall = !rdy; prev_data = tx_data;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; tx_ready = 1'b0;
    total_cnt++;
    if (cyc >= 200) $display("FAIL %s timeout: frame still running after %0d cycles", name, cyc);
    else pass_cnt++;
    total_cnt++;
    if (got.size() !== exp_q.size())
      $display("FAIL %s length: got %0d bytes, required %0d", name, got.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      total_cnt++;
      if (got[i] !== exp_q[i])
        $display("FAIL %s byte%0d: got %h required %h", name, i, got[i], exp_q[i]);
      else pass_cnt++;
    end
    if (ready_mode == 0) begin
      total_cnt++;
      if (cyc !== exp_q.size())
        $display("FAIL %s busy_cycles: got %0d required %0d", name, cyc, exp_q.size());
      else pass_cnt++;
    end
    total_cnt++;
    if (done !== 1'b1 || error !== 1'b0)
      $display("FAIL %s end_state: done=%b error=%b required done=1 error=0", name, done, error);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({tx_data, tx_valid, done, error} !== {8'h00, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_values: tx_data=%h tx_valid=%b done=%b error=%b required 00 0 1 0",
               tx_data, tx_valid, done, error);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_frame("cmd1_enc", 1, 1'b1, 48'h0, 16'h0, 0, -1);
    total_cnt++;
    if (exp_q[9] !== 8'h01) $display("FAIL cmd1_model_csum: got %h required 01", exp_q[9]);
    else pass_cnt++;
    run_frame("cmd2_yawreq", 2, 1'b0, 48'h112233445566, 16'h0, 0, -1);
    total_cnt++;
    if (exp_q[8] !== 8'h74) $display("FAIL cmd2_model_csum: got %h required 74", exp_q[8]);
    else pass_cnt++;
    run_frame("cmd3_stall", 3, 1'b0, 48'h112233445566, 16'hABCD, 1, -1);
    total_cnt++;
    if (exp_q[10] !== 8'h17) $display("FAIL cmd3_model_csum: got %h required 17", exp_q[10]);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    cmd_select = 16'h7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (error !== 1'b1 || tx_valid !== 1'b0 || done !== 1'b1)
      $display("FAIL illegal_cmd: error=%b tx_valid=%b done=%b required 1 0 1", error, tx_valid, done);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (error !== 1'b1 || tx_valid !== 1'b0)
      $display("FAIL illegal_hold: error=%b tx_valid=%b required 1 0", error, tx_valid);
    else pass_cnt++;
    run_frame("after_illegal", 2, 1'b0, 48'h112233445566, 16'h0, 0, -1);
  endtask

  task automatic test_reset_mid_frame();
    build_expected(3, 1'b0, 48'hA1B2C3D4E5F6, 16'h1234);
    cmd_select = 16'd3; target_addr = 48'hA1B2C3D4E5F6; yaw_data = 16'h1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (tx_valid !== 1'b1 || tx_data !== exp_q[i])
        $display("FAIL rst_mid_byte%0d: valid=%b data=%h required 1 %h", i, tx_valid, tx_data, exp_q[i]);
      else pass_cnt++;
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (tx_valid !== 1'b0 || done !== 1'b1 || tx_data !== 8'h00)
      $display("FAIL rst_mid_abort: tx_valid=%b done=%b tx_data=%h required 0 1 00", tx_valid, done, tx_data);
    else pass_cnt++;
    reset = 1'b1;
    tx_ready = 1'b0;
    @(negedge clk);
    run_frame("after_reset", 1, 1'b0, 48'h0, 16'h0, 0, -1);
  endtask

  task automatic test_start_mid_frame();
    run_frame("mid_start", 3, 1'b1, 48'hCAFE_F00D_1234, 16'h5A5A, 2, 4);
    run_frame("mid_start2", 2, 1'b0, 48'h0102_0304_0506, 16'h0, 0, 2);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_a", 1, 1'b1, 48'h0, 16'h0, 0, -1);
    run_frame("b2b_b", 3, 1'b0, 48'h9988_7766_5544, 16'hFEDC, 0, -1);
    run_frame("b2b_c", 2, 1'b0, 48'h0000_0000_0001, 16'h0, 0, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      if ($urandom % 4 == 0) begin
        cmd_select = 16'($urandom_range(4, 16'hFFFF));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total_cnt++;
        if (error !== 1'b1 || tx_valid !== 1'b0)
          $display("FAIL rand_illegal: error=%b tx_valid=%b required 1 0", error, tx_valid);
        else pass_cnt++;
      end
      run_frame("random", int'($urandom_range(1, 3)), 1'($urandom),
                {$urandom, $urandom}, 16'($urandom), 2, -1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_reset_mid_frame();
    test_start_mid_frame();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ble_uart_command_enc_tx.md
# ble_uart_command_enc_tx

Frame encoder for the BLE UART command link; the transmit-side counterpart of the command decoder. On a `start` pulse it latches a command selection and its operands, then serializes one command frame byte-by-byte to the UART transmitter over a valid/ready handshake, appending an XOR checksum. It sits between the control logic (encryption-mode and yaw-report requests) and the UART TX byte interface.

## Interface
- `OPC_ENC`, 8'h01, opcode for the set-encryption command
- `OPC_YAW_REQ`, 8'h03, opcode for the read-yaw request
- `OPC_YAW_RSP`, 8'h04, opcode for the yaw-data response
- `BCAST_ADDR`, 48'hFFFF_FFFF_FFFF, address inserted for the set-encryption command
- `clk`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  request pulse; sampled only in IDLE
- `cmd_select`  in  16  1 = set encryption, 2 = yaw request, 3 = yaw response; others illegal
- `encrypt_enable`  in  1  payload bit for cmd 1
- `target_addr`  in  48  device address for cmds 2 and 3
- `yaw_data`  in  16  payload for cmd 3
- `tx_data`  out  8  current frame byte
- `tx_valid`  out  1  `tx_data` is valid
- `tx_ready`  in  1  UART TX accepts the byte this cycle
- `done`  out  1  high when idle (no frame in progress)
- `error`  out  1  last `start` carried an illegal `cmd_select`

## Operation
- Frame byte i = bits [8i+7:8i] of the frame. Layout: byte0 opcode; bytes1-6 address, LS byte first; byte7 payload length L; bytes 8..7+L payload; final byte checksum = XOR of all preceding bytes.
- cmd 1: opcode `OPC_ENC`, address `BCAST_ADDR`, L=1, payload {7'b0, encrypt_enable}; 10 bytes total.
- cmd 2: opcode `OPC_YAW_REQ`, address `target_addr`, L=0; 9 bytes total.
- cmd 3: opcode `OPC_YAW_RSP`, address `target_addr`, L=2, payload yaw_data[7:0] then yaw_data[15:8]; 11 bytes total.
- All operands are latched on the accepting `start` edge. Input changes afterward do not affect the frame in flight.
- States:
  - IDLE: `done`=1, `tx_valid`=0. Legal `start` → SEND with byte index 0, `error`←0, `done`←0. Illegal `start` → remain IDLE, `error`←1, no bytes sent.
  - SEND: presents header and payload bytes. The index and the running XOR advance only on `tx_valid && tx_ready`. After the last payload byte, or after byte7 when L=0, → CSUM.
  - CSUM: presents the checksum byte. On handshake → IDLE.
- `error` holds until the next accepted `start`.
- `start` asserted outside IDLE is ignored and does not set `error`.

## Timing
- Reset values: `tx_data`=8'h00, `tx_valid`=0, `done`=1, `error`=0, state IDLE, index and XOR cleared.
- `start` sampled at edge N: `tx_valid`=1 with byte0 from cycle N+1.
- Handshake: `tx_data` stays stable and `tx_valid` stays high until `tx_ready`. Each handshake at edge M presents the next byte in cycle M+1, with no bubbles. `tx_valid` never deasserts mid-frame except on reset.
- With `tx_ready` held high, a B-byte frame occupies cycles N+1..N+B. `done` rises at N+B+1, and `tx_valid` is 0 from that cycle.
- A `start` in the same cycle that `done` first returns high is accepted; back-to-back frames are separated by exactly one idle cycle.
- Reset low mid-frame: at the next edge all outputs take reset values and the partial frame is abandoned, with no checksum sent.
- `error` updates on the edge that samples the illegal `start`, so it is visible in cycle N+1.

## Test plan
- cmd 1, `encrypt_enable`=1, `tx_ready`=1 → bytes 01 FF FF FF FF FF FF 01 01 01; `done` high 11 cycles after the `start` edge.
- cmd 2, `target_addr`=48'h112233445566 → bytes 03 66 55 44 33 22 11 00 74.
- cmd 3, same address, `yaw_data`=16'hABCD, `tx_ready` toggling 1/0 each cycle → bytes 04 66 55 44 33 22 11 02 CD AB 17. Check `tx_data` stable during every stall, with no duplicated or dropped bytes.
- `cmd_select`=16'h7 → `error`=1 in the next cycle, `tx_valid` stays 0, `done` stays 1. A following legal cmd 2 clears `error` and sends a normal frame.
- Reset low after the 4th byte of a cmd 3 frame → `tx_valid`=0 and `done`=1 the next cycle. A new cmd 1 then sends a complete, correct 10-byte frame.
- `start` pulsed mid-frame with different operands → ignored; the current frame completes unchanged and `error` stays 0.
